// File: rtl/address_decoder_mapper.sv
// ---------------------------------------------------------------------------
// address_decoder_mapper
//
// Purpose:
//   Decodes a CPU bus address into one of NUM_REGIONS programmable regions.
//   Each region has a base, a mask and an enable bit. A region matches when
//   it is enabled and the masked address equals the masked base. The
//   lowest-numbered matching region wins, so the select vector is at most
//   one-hot. The select is registered two clocks after the address strobe
//   is first seen low. It is held until the strobe goes high again.
//
// Optional feature (macro DECODE_TIMEOUT_EN):
//   - An unmapped access raises a bus error straight from DECODE.
//   - A watchdog counts WAIT clocks until the first acknowledge arrives.
//     When the count reaches TIMEOUT_CYCLES, it raises a bus error.
//   Without the macro, Berr_L is tied high and there is no counter.
//   An unmapped access only raises Unmapped_H.
//
// Ports:
//   Clk         - rising-edge clock
//   Reset_L     - synchronous active-low reset
//   AS_L        - CPU address strobe, active-low
//   Address     - CPU address
//   DtackIn_L   - combined device acknowledge, active-low
//   CfgWrite_H  - one-clock configuration write strobe
//   CfgIndex    - region being written
//   CfgField    - 0 base, 1 mask, 2 enable (CfgData[0]), 3 ignored
//   CfgData     - configuration write data
//   Select_H    - registered one-hot region selects
//   Unmapped_H  - current access matched no enabled region
//   Berr_L      - bus error to the CPU, active-low
// ---------------------------------------------------------------------------
module address_decoder_mapper #(
   parameter int NUM_REGIONS    = 8,
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                   Clk,
   input  logic                   Reset_L,
   input  logic                   AS_L,
   input  logic [ADDR_WIDTH-1:0]  Address,
   input  logic                   DtackIn_L,
   input  logic                   CfgWrite_H,
   input  logic [3:0]             CfgIndex,
   input  logic [1:0]             CfgField,
   input  logic [ADDR_WIDTH-1:0]  CfgData,
   output logic [NUM_REGIONS-1:0] Select_H,
   output logic                   Unmapped_H,
   output logic                   Berr_L
);

   typedef enum logic [1:0] {IDLE, DECODE, WAIT, BERR} stateT;

   stateT                  state, stateNext;
   logic [ADDR_WIDTH-1:0]  addrReg, addrNext;
   logic [NUM_REGIONS-1:0] selectReg, selectNext;
   logic                   unmappedReg, unmappedNext;
   logic [NUM_REGIONS-1:0] matchVec;
   logic [NUM_REGIONS-1:0] grant;

   logic [ADDR_WIDTH-1:0]  regionBase [NUM_REGIONS];
   logic [ADDR_WIDTH-1:0]  regionMask [NUM_REGIONS];
   logic [NUM_REGIONS-1:0] regionEnable;

`ifdef DECODE_TIMEOUT_EN
   logic        berrReg, berrNext;
   logic [15:0] count, countNext;
   logic        dtackSeen, dtackSeenNext;
`else
   logic        unusedDtack;
   logic [15:0] unusedTimeout;
`endif

   // Region map registers. Reset restores the boot map: a low RAM window,
   // a ROM window near the top of memory and an I/O window. Writes to a
   // region index that does not exist are dropped. Writes to field 3 are
   // dropped too. Each index is compared explicitly, so an out-of-range
   // index can never alias onto a real region.
   always_ff @(posedge Clk) begin
      if (!Reset_L) begin
         for (int i = 0; i < NUM_REGIONS; i++) begin
            regionBase[i]   <= '0;
            regionMask[i]   <= '0;
            regionEnable[i] <= 1'b0;
         end
         regionBase[0]   <= ADDR_WIDTH'(32'h0000_0000);
         regionMask[0]   <= ADDR_WIDTH'(32'hFFFF_8000);
         regionEnable[0] <= 1'b1;
         regionBase[1]   <= ADDR_WIDTH'(32'hF000_0000);
         regionMask[1]   <= ADDR_WIDTH'(32'hFFFC_0000);
         regionEnable[1] <= 1'b1;
         regionBase[2]   <= ADDR_WIDTH'(32'h0040_0000);
         regionMask[2]   <= ADDR_WIDTH'(32'hFFFF_0000);
         regionEnable[2] <= 1'b1;
      end else if (CfgWrite_H) begin
         for (int i = 0; i < NUM_REGIONS; i++) begin
            if (CfgIndex == 4'(i)) begin
               case (CfgField)
                  2'd0:    regionBase[i]   <= CfgData;
                  2'd1:    regionMask[i]   <= CfgData;
                  2'd2:    regionEnable[i] <= CfgData[0];
                  default: ;
               endcase
            end
         end
      end
   end

   // Match every region against the captured address. Then keep only the
   // lowest-numbered hit. The loop walks downward, so later iterations
   // (lower indices) override earlier ones.
   always_comb begin
      matchVec = '0;
      grant    = '0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
         matchVec[i] = regionEnable[i] &&
                       ((addrReg & regionMask[i]) == (regionBase[i] & regionMask[i]));
      end
      for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
         if (matchVec[i]) begin
            grant    = '0;
            grant[i] = 1'b1;
         end
      end
   end

   // Next-state and next-output logic. Any state returns to IDLE when the
   // strobe is seen high. That return clears the outputs and the watchdog.
   // IDLE accepts a new strobe on the very next edge, so back-to-back
   // accesses need no dead cycle.
   always_comb begin
      stateNext    = state;
      addrNext     = addrReg;
      selectNext   = selectReg;
      unmappedNext = unmappedReg;
`ifdef DECODE_TIMEOUT_EN
      berrNext      = berrReg;
      countNext     = count;
      dtackSeenNext = dtackSeen;
`endif
      if (AS_L) begin
         stateNext    = IDLE;
         selectNext   = '0;
         unmappedNext = 1'b0;
`ifdef DECODE_TIMEOUT_EN
         berrNext      = 1'b1;
         countNext     = '0;
         dtackSeenNext = 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               addrNext     = Address;
               selectNext   = '0;
               unmappedNext = 1'b0;
               stateNext    = DECODE;
            end
            DECODE: begin
               selectNext   = grant;
               unmappedNext = (grant == '0);
               stateNext    = WAIT;
`ifdef DECODE_TIMEOUT_EN
               if (grant == '0) begin
                  stateNext = BERR;
                  berrNext  = 1'b0;
               end
`endif
            end
            WAIT: begin
`ifdef DECODE_TIMEOUT_EN
               if (!DtackIn_L) begin
                  dtackSeenNext = 1'b1;
               end else if (!dtackSeen) begin
                  countNext = count + 16'd1;
                  if (count + 16'd1 == 16'(TIMEOUT_CYCLES)) begin
                     stateNext  = BERR;
                     berrNext   = 1'b0;
                     selectNext = '0;
                  end
               end
`endif
            end
            BERR: begin
               selectNext = '0;
`ifdef DECODE_TIMEOUT_EN
               berrNext   = 1'b0;
`endif
            end
            default: stateNext = IDLE;
         endcase
      end
   end

   // State and output registers. Reset drops any access in flight without
   // raising a bus error.
   always_ff @(posedge Clk) begin
      if (!Reset_L) begin
         state       <= IDLE;
         addrReg     <= '0;
         selectReg   <= '0;
         unmappedReg <= 1'b0;
`ifdef DECODE_TIMEOUT_EN
         berrReg     <= 1'b1;
         count       <= '0;
         dtackSeen   <= 1'b0;
`endif
      end else begin
         state       <= stateNext;
         addrReg     <= addrNext;
         selectReg   <= selectNext;
         unmappedReg <= unmappedNext;
`ifdef DECODE_TIMEOUT_EN
         berrReg     <= berrNext;
         count       <= countNext;
         dtackSeen   <= dtackSeenNext;
`endif
      end
   end

   assign Select_H   = selectReg;
   assign Unmapped_H = unmappedReg;
`ifdef DECODE_TIMEOUT_EN
   assign Berr_L     = berrReg;
`else
   assign Berr_L        = 1'b1;
   assign unusedDtack   = DtackIn_L;
   assign unusedTimeout = 16'(TIMEOUT_CYCLES);
`endif

endmodule
